load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data and address width; only 32 is supported.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous, active-high.
REQ-004 req_valid  input  1  SHALL indicate the execute stage presents a memory op.
REQ-005 req_ready  output  1  SHALL indicate the LSU accepts a request this cycle.
REQ-006 req_we  input  1  SHALL select store (1) or load (0).
REQ-007 req_size  input  2  SHALL encode access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 req_unsigned  input  1  SHALL select zero-extension (1) or sign-extension (0) for loads.
REQ-009 req_addr  input  DATA_WIDTH  SHALL be the byte address, i.e. the ALU ADD result.
REQ-010 req_wdata  input  DATA_WIDTH  SHALL be store data, right-aligned.
REQ-011 mem_req / mem_we  output  1 / 1  SHALL be bus request and write strobe.
REQ-012 mem_addr  output  DATA_WIDTH  SHALL be the word-aligned bus address (bits [1:0] = 0).
REQ-013 mem_be / mem_wdata  output  4 / DATA_WIDTH  SHALL be byte enables and lane-positioned write data.
REQ-014 mem_gnt / mem_rvalid / mem_rdata  input  1 / 1 / DATA_WIDTH  SHALL be grant, read-valid, read data.
REQ-015 rsp_valid / rsp_err / rsp_data  output  1 / 1 / DATA_WIDTH  SHALL be completion pulse, error flag, extended load data.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT_R, RESP; req_ready = 1 only in IDLE.
REQ-017 In IDLE with req_valid=1, all request fields SHALL be registered and the FSM SHALL go to REQ, or to RESP with rsp_err=1 if the access is illegal (REQ-026).
REQ-018 In REQ, mem_req=1 and mem_addr/mem_we/mem_be/mem_wdata SHALL be held stable until mem_gnt=1.
REQ-019 On grant: a store SHALL go to RESP; a load SHALL go to WAIT_R; mem_rvalid in the grant cycle SHALL be ignored.
REQ-020 In WAIT_R, mem_rvalid=1 SHALL capture the extended load data and go to RESP; wait is unbounded.
REQ-021 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then go to IDLE; there is no response backpressure.
REQ-022 mem_be SHALL be 0001<<a for byte, 0011<<a for half, and 1111 for word, where a = addr[1:0].
REQ-023 mem_wdata SHALL replicate the byte (4x) or half (2x) across lanes; word is passed unchanged.
REQ-024 Load data SHALL be mem_rdata >> (8*a), truncated to size, then sign- or zero-extended per req_unsigned; word is passed unchanged.
REQ-025 rsp_data SHALL be 0 for stores and for errored ops; rsp_err SHALL be 0 on success.
REQ-026 size=11 SHALL always be illegal: no bus activity, completes in RESP one cycle after acceptance.
REQ-027 Minimum latency SHALL be acceptance to rsp_valid = 2 cycles for a store with same-cycle grant, and 3 cycles for a load with rvalid in the cycle after grant.
REQ-028 mem_rvalid outside WAIT_R and mem_gnt outside REQ SHALL be ignored.

Reset
REQ-029 On rst, the FSM SHALL go to IDLE and all outputs SHALL be 0 except req_ready=1, including mid-transaction; a late rvalid after reset SHALL be ignored.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN, when defined, SHALL make half with addr[0]=1 and word with addr[1:0]!=0 illegal per REQ-026.
REQ-031 Without LSU_MISALIGN_TRAP_EN, such accesses SHALL proceed with a forced to natural alignment (half: a[0]=0; word: a=00) and rsp_err=0.

Verification
REQ-032 Store byte, addr=0x1003, wdata=0xAB, gnt same cycle -> mem_addr=0x1000, mem_be=1000, mem_wdata=0xABABABAB, rsp_valid 2 cycles after accept.
REQ-033 Load byte signed, addr=0x2001, rdata=0x00008000 after a 3-cycle gnt delay -> rsp_data=0xFFFFFF80; repeat with unsigned -> 0x00000080.
REQ-034 Load half, addr=0x3002, rdata=0x1234ABCD -> mem_be=1100, rsp_data=0x00001234 (signed).
REQ-035 Word load, addr=0x4002: with macro -> rsp_err=1, mem_req never asserted; without macro -> mem_addr=0x4000, mem_be=1111.
REQ-036 Assert rst while in WAIT_R, then pulse rvalid -> outputs at reset values, no rsp_valid, req_ready=1.
REQ-037 req_size=11 -> rsp_err=1, rsp_data=0, zero mem_req cycles.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding memory op, byte/half/word with lane steering and extension.
// Optional define LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module load_store_unit #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  rsp_valid,
   output logic                  rsp_err,
   output logic [DATA_WIDTH-1:0] rsp_data
);

   typedef enum logic [1:0] {StIdle, StReq, StWaitR, StResp} state_e;

   localparam logic [1:0] SzByte = 2'b00;
   localparam logic [1:0] SzHalf = 2'b01;
   localparam logic [1:0] SzWord = 2'b10;

   state_e                state_q, state_d;
   logic                  we_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [DATA_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] data_q;

   logic [1:0]            off_acc;
   logic                  illegal;
   logic [DATA_WIDTH-1:0] rd_shift;
   logic [DATA_WIDTH-1:0] ld_ext;
   logic [3:0]            be_raw;
   logic [DATA_WIDTH-1:0] wdata_raw;
   logic                  accept;
   logic                  in_req;

   assign accept = (state_q == StIdle) && req_valid;

   // Offset used for the access; misaligned half/word fall back to natural alignment.
   always_comb begin
      off_acc = req_addr[1:0];
      if (req_size == SzHalf) off_acc[0] = 1'b0;
      if (req_size == SzWord) off_acc = 2'b00;
      illegal = (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
      if (req_size == SzHalf && req_addr[0]) illegal = 1'b1;
      if (req_size == SzWord && req_addr[1:0] != 2'b00) illegal = 1'b1;
`endif
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) state_d = illegal ? StResp : StReq;
         end
         StReq: begin
            if (mem_gnt) state_d = we_q ? StResp : StWaitR;
         end
         StWaitR: begin
            if (mem_rvalid) state_d = StResp;
         end
         StResp: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Load lane extraction and extension.
   always_comb begin
      rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
      unique case (size_q)
         SzByte: ld_ext = uns_q ? {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]}
                                : {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
         SzHalf: ld_ext = uns_q ? {{(DATA_WIDTH-16){1'b0}}, rd_shift[15:0]}
                                : {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
         default: ld_ext = mem_rdata;
      endcase
   end

   // Store lane steering.
   always_comb begin
      unique case (size_q)
         SzByte: begin
            be_raw    = 4'b0001 << addr_q[1:0];
            wdata_raw = {4{wdata_q[7:0]}};
         end
         SzHalf: begin
            be_raw    = 4'b0011 << addr_q[1:0];
            wdata_raw = {2{wdata_q[15:0]}};
         end
         default: begin
            be_raw    = 4'b1111;
            wdata_raw = wdata_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= {req_addr[DATA_WIDTH-1:2], off_acc};
            wdata_q <= req_wdata;
            err_q   <= illegal;
            data_q  <= '0;
         end
         if (state_q == StWaitR && mem_rvalid) data_q <= ld_ext;
      end
   end

   // Bus fields are only driven while requesting; idle values are zero.
   assign in_req    = (state_q == StReq);
   assign req_ready = (state_q == StIdle);
   assign mem_req   = in_req;
   assign mem_we    = in_req & we_q;
   assign mem_addr  = in_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
   assign mem_be    = in_req ? be_raw : 4'b0000;
   assign mem_wdata = in_req ? wdata_raw : '0;
   assign rsp_valid = (state_q == StResp);
   assign rsp_err   = rsp_valid & err_q;
   assign rsp_data  = rsp_valid ? data_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit plus hand-written reset sequences.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_data;

   int          n_total = 0;
   int          n_pass  = 0;

   always #5 clk = ~clk;

   load_store_unit #(.DATA_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_size    (req_size),
      .req_unsigned(req_unsigned),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_be      (mem_be),
      .mem_wdata   (mem_wdata),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .rsp_valid   (rsp_valid),
      .rsp_err     (rsp_err),
      .rsp_data    (rsp_data)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          dly;
      logic        e_err;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_idle(input string tag);
      check({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
      check({tag, " mem_req"},   {31'b0, mem_req},   32'd0);
      check({tag, " mem_we"},    {31'b0, mem_we},    32'd0);
      check({tag, " mem_addr"},  mem_addr,           32'd0);
      check({tag, " mem_be"},    {28'b0, mem_be},    32'd0);
      check({tag, " mem_wdata"}, mem_wdata,          32'd0);
      check({tag, " rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
      check({tag, " rsp_err"},   {31'b0, rsp_err},   32'd0);
      check({tag, " rsp_data"},  rsp_data,           32'd0);
   endtask

   task automatic run_vec(input int i, input vec_t v);
      string t;
      t = $sformatf("v%0d", i);
      @(negedge clk);
      check({t, " ready"}, {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata;
      @(negedge clk);
      req_valid = 1'b0;
      if (v.e_err) begin
         check({t, " err mem_req"},   {31'b0, mem_req},   32'd0);
         check({t, " err rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
         check({t, " err rsp_err"},   {31'b0, rsp_err},   32'd1);
         check({t, " err rsp_data"},  rsp_data,           32'd0);
      end else begin
         for (int k = 0; k <= v.dly; k++) begin
            check({t, " mem_req"},   {31'b0, mem_req}, 32'd1);
            check({t, " mem_we"},    {31'b0, mem_we},  {31'b0, v.we});
            check({t, " mem_addr"},  mem_addr,         v.e_addr);
            check({t, " mem_be"},    {28'b0, mem_be},  {28'b0, v.e_be});
            check({t, " mem_wdata"}, mem_wdata,        v.e_wdata);
            check({t, " early rsp"}, {31'b0, rsp_valid}, 32'd0);
            if (k == v.dly) begin
               mem_gnt = 1'b1;
               // rvalid during the grant cycle must be ignored
               mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
            end
            @(negedge clk);
         end
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         if (!v.we) begin
            check({t, " wait mem_req"}, {31'b0, mem_req},   32'd0);
            check({t, " wait rsp"},     {31'b0, rsp_valid}, 32'd0);
            mem_rvalid = 1'b1; mem_rdata = v.rdata;
            @(negedge clk);
            mem_rvalid = 1'b0; mem_rdata = 32'h0;
         end
         check({t, " rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
         check({t, " rsp_err"},   {31'b0, rsp_err},   32'd0);
         check({t, " rsp_data"},  rsp_data,           v.e_data);
      end
      @(negedge clk);
      check({t, " rsp pulse"}, {31'b0, rsp_valid}, 32'd0);
      check({t, " back idle"}, {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      //           we  sz     un  addr          wdata         rdata         dly err addr          be       wdata         data
      vecs[0]  = '{1, 2'b00, 0, 32'h0000_1003, 32'h0000_00AB, 32'h0,        0, 0, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0};
      vecs[1]  = '{0, 2'b00, 0, 32'h0000_2001, 32'h0,        32'h0000_8000, 3, 0, 32'h0000_2000, 4'b0010, 32'h0,        32'hFFFF_FF80};
      vecs[2]  = '{0, 2'b00, 1, 32'h0000_2001, 32'h0,        32'h0000_8000, 3, 0, 32'h0000_2000, 4'b0010, 32'h0,        32'h0000_0080};
      vecs[3]  = '{0, 2'b01, 0, 32'h0000_3002, 32'h0,        32'h1234_ABCD, 0, 0, 32'h0000_3000, 4'b1100, 32'h0,        32'h0000_1234};
`ifdef LSU_MISALIGN_TRAP_EN
      vecs[4]  = '{0, 2'b10, 0, 32'h0000_4002, 32'h0,        32'hCAFE_F00D, 0, 1, 32'h0,        4'b0000, 32'h0,        32'h0};
      vecs[9]  = '{0, 2'b01, 1, 32'h0000_8003, 32'h0,        32'hFEDC_0000, 0, 1, 32'h0,        4'b0000, 32'h0,        32'h0};
`else
      vecs[4]  = '{0, 2'b10, 0, 32'h0000_4002, 32'h0,        32'hCAFE_F00D, 0, 0, 32'h0000_4000, 4'b1111, 32'h0,        32'hCAFE_F00D};
      vecs[9]  = '{0, 2'b01, 1, 32'h0000_8003, 32'h0,        32'hFEDC_0000, 0, 0, 32'h0000_8000, 4'b1100, 32'h0,        32'h0000_FEDC};
`endif
      vecs[5]  = '{0, 2'b11, 0, 32'h0000_5000, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0};
      vecs[6]  = '{1, 2'b01, 0, 32'h0000_6002, 32'h1234_BEEF, 32'h0,        1, 0, 32'h0000_6000, 4'b1100, 32'hBEEF_BEEF, 32'h0};
      vecs[7]  = '{1, 2'b10, 0, 32'h0000_7000, 32'h89AB_CDEF, 32'h0,        0, 0, 32'h0000_7000, 4'b1111, 32'h89AB_CDEF, 32'h0};
      vecs[8]  = '{0, 2'b01, 0, 32'h0000_8000, 32'h0,        32'h0000_F00F, 2, 0, 32'h0000_8000, 4'b0011, 32'h0,        32'hFFFF_F00F};
      vecs[10] = '{1, 2'b11, 0, 32'h0000_A001, 32'h1111_1111, 32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0};
      vecs[11] = '{0, 2'b00, 1, 32'h0000_9003, 32'h0,        32'h7F00_0000, 0, 0, 32'h0000_9000, 4'b1000, 32'h0,        32'h0000_007F};

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;

      // Stray grant/rvalid while idle must have no effect.
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      check_idle("stray");

      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // Reset while waiting for read data, then a late rvalid.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0000_B000;
      @(negedge clk);
      req_valid = 1'b0;
      check("rw mem_req", {31'b0, mem_req}, 32'd1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      check("rw in wait", {31'b0, req_ready}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h0000_0080;
      check_idle("rst wait");
      @(negedge clk);
      mem_rvalid = 1'b0;
      check_idle("late rvalid");
      @(negedge clk);
      check_idle("after late");

      // Reset while requesting: bus request must drop.
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0000_C000;
      req_wdata = 32'h5555_AAAA;
      @(negedge clk);
      req_valid = 1'b0;
      check("rr mem_req", {31'b0, mem_req}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("rst req");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
